// File: rtl/uart_packet_parser_if.sv
// rtl/uart_packet_parser_if.sv - byte-in / payload-out bundle for the UART packet parser
interface uart_packet_parser_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic [6:0] addr;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       pkt_ok;
    logic       pkt_err;
    logic       busy;

    modport master (
        output in_data, in_valid,
        input  addr, out_data, out_valid, out_sop, out_eop, pkt_ok, pkt_err, busy
    );

    modport slave (
        input  in_data, in_valid,
        output addr, out_data, out_valid, out_sop, out_eop, pkt_ok, pkt_err, busy
    );
endinterface

// File: rtl/uart_packet_parser.sv
// rtl/uart_packet_parser.sv - frames PREFIX/addr/len/payload/crc packets from a UART byte stream
module uart_packet_parser #(
    parameter logic [7:0] PREFIX    = 8'hEE,
    parameter bit         CHECK_CRC = 1'b0,
    parameter int         TIMEOUT   = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_packet_parser_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CRC
    } state_t;

    localparam logic [17:0] IDLE_LAST = 18'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  crc_q, crc_d;
    logic        first_q, first_d;
    logic [17:0] idle_q, idle_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sop_q, out_sop_d;
    logic        out_eop_q, out_eop_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        pkt_err_q, pkt_err_d;
    logic        busy_q, busy_d;
    logic        timeout;

    // A byte arriving on the last idle cycle wins over the timeout.
    assign timeout = (state_q != S_IDLE) && !bus.in_valid && (idle_q == IDLE_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        first_d     = first_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        pkt_ok_d    = 1'b0;
        pkt_err_d   = 1'b0;
        idle_d      = (bus.in_valid || state_q == S_IDLE) ? 18'd0 : idle_q + 18'd1;

        if (bus.in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_data == PREFIX) begin
                        state_d = S_ADDR;
                    end
                end
                S_ADDR: begin
                    addr_d  = bus.in_data[6:0];
                    crc_d   = bus.in_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    cnt_d = bus.in_data;
                    crc_d = crc_q ^ bus.in_data;
                    if (bus.in_data == 8'd0) begin
                        pkt_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        first_d = 1'b1;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    out_data_d  = bus.in_data;
                    out_valid_d = 1'b1;
                    out_sop_d   = first_q;
                    out_eop_d   = (cnt_q == 8'd1);
                    first_d     = 1'b0;
                    crc_d       = crc_q ^ bus.in_data;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    if (!CHECK_CRC || bus.in_data == crc_q) begin
                        pkt_ok_d = 1'b1;
                    end else begin
                        pkt_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (timeout) begin
            pkt_err_d = 1'b1;
            state_d   = S_IDLE;
            idle_d    = 18'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 7'd0;
            cnt_q       <= 8'd0;
            crc_q       <= 8'd0;
            first_q     <= 1'b0;
            idle_q      <= 18'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_ok_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            first_q     <= first_d;
            idle_q      <= idle_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_err_q   <= pkt_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.pkt_ok    = pkt_ok_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_packet_parser.sv
// tb/tb_uart_packet_parser.sv - scoreboard bench driving CRC-checking and non-checking parsers in parallel
module tb_uart_packet_parser;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;

    always #5 clk = ~clk;

    uart_packet_parser_if if_c ();
    uart_packet_parser_if if_n ();

    assign if_c.in_data  = in_data;
    assign if_c.in_valid = in_valid;
    assign if_n.in_data  = in_data;
    assign if_n.in_valid = in_valid;

    uart_packet_parser #(.PREFIX(8'hEE), .CHECK_CRC(1'b1), .TIMEOUT(TO)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave)
    );
    uart_packet_parser #(.PREFIX(8'hEE), .CHECK_CRC(1'b0), .TIMEOUT(TO)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n.slave)
    );

    typedef struct {
        int         stamp;
        int         kind;     // 0 data, 1 pkt_ok, 2 pkt_err
        logic [6:0] addr;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t q_c[$];
    exp_t q_n[$];
    int   cyc = 0;
    int   stamp = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        stamp    = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic exp_data(input logic [6:0] a, input logic [7:0] d, input logic s, input logic e);
        exp_t x;
        x.stamp = stamp; x.kind = 0; x.addr = a; x.data = d; x.sop = s; x.eop = e;
        q_c.push_back(x);
        q_n.push_back(x);
    endtask

    task automatic exp_end(input int kind_c, input int kind_n, input int st);
        exp_t x;
        x.stamp = st; x.addr = 7'd0; x.data = 8'd0; x.sop = 1'b0; x.eop = 1'b0;
        x.kind = kind_c;
        q_c.push_back(x);
        x.kind = kind_n;
        q_n.push_back(x);
    endtask

    task automatic mon(input int which, input logic v, input logic ok, input logic err,
                       input logic [6:0] a, input logic [7:0] d, input logic s, input logic e);
        exp_t x;
        int   k;
        int   empty;
        string tag;
        if (v === 1'b1 || ok === 1'b1 || err === 1'b1) begin
            tag   = (which == 0) ? "crc" : "nocrc";
            empty = (which == 0) ? (q_c.size() == 0) : (q_n.size() == 0);
            if (empty != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_unexpected: got v=%0b ok=%0b err=%0b, expected no output (cycle %0d)",
                         tag, v, ok, err, cyc);
            end else begin
                if (which == 0) x = q_c.pop_front();
                else            x = q_n.pop_front();
                k = (int'(v) + int'(ok) + int'(err) > 1) ? 3 : (v ? 0 : (ok ? 1 : 2));
                chk({tag, "_kind"}, k, x.kind);
                chk({tag, "_latency"}, cyc, x.stamp);
                if (x.kind == 0) begin
                    chk({tag, "_addr"}, {25'd0, a}, {25'd0, x.addr});
                    chk({tag, "_data"}, {24'd0, d}, {24'd0, x.data});
                    chk({tag, "_sop_eop"}, {30'd0, s, e}, {30'd0, x.sop, x.eop});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if_c.out_valid, if_c.pkt_ok, if_c.pkt_err, if_c.addr, if_c.out_data, if_c.out_sop, if_c.out_eop);
        mon(1, if_n.out_valid, if_n.pkt_ok, if_n.pkt_err, if_n.addr, if_n.out_data, if_n.out_sop, if_n.out_eop);
    end

    task automatic chk_zero(input string name);
        chk({name, "_c"}, {11'd0, if_c.addr, if_c.out_data, if_c.out_valid, if_c.out_sop, if_c.out_eop,
                            if_c.pkt_ok, if_c.pkt_err, if_c.busy}, 32'd0);
        chk({name, "_n"}, {11'd0, if_n.addr, if_n.out_data, if_n.out_valid, if_n.out_sop, if_n.out_eop,
                            if_n.pkt_ok, if_n.pkt_err, if_n.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b0;
        idle(2);

        // Basic packet: addr 09, payload 16 1D, CRC byte CC (real CRC is 00).
        send(8'hEE);
        send(8'h09);
        chk("busy_after_prefix", {31'd0, if_c.busy}, 32'd1);
        send(8'h02);
        send(8'h16); exp_data(7'h09, 8'h16, 1'b1, 1'b0);
        send(8'h1D); exp_data(7'h09, 8'h1D, 1'b0, 1'b1);
        send(8'hCC); exp_end(2, 1, stamp);
        idle(3);
        chk("busy_after_pkt", {30'd0, if_c.busy, if_n.busy}, 32'd0);

        // Same packet with correct CRC.
        send(8'hEE); send(8'h09); send(8'h02);
        send(8'h16); exp_data(7'h09, 8'h16, 1'b1, 1'b0);
        send(8'h1D); exp_data(7'h09, 8'h1D, 1'b0, 1'b1);
        send(8'h00); exp_end(1, 1, stamp);
        idle(3);

        // Leading garbage, then a one-byte payload equal to the prefix (CRC F7, sent 33).
        send(8'h11); send(8'h22);
        send(8'hEE); send(8'h18); send(8'h01);
        send(8'hEE); exp_data(7'h18, 8'hEE, 1'b1, 1'b1);
        send(8'h33); exp_end(2, 1, stamp);
        idle(3);

        // Zero length aborts; addr stays latched.
        send(8'hEE); send(8'h0A);
        send(8'h00); exp_end(2, 2, stamp);
        idle(2);
        chk("busy_after_len0", {30'd0, if_c.busy, if_n.busy}, 32'd0);
        chk("addr_held_len0", {25'd0, if_c.addr}, 32'h0A);
        send(8'hEE); send(8'h0B); send(8'h02);
        send(8'hA0); exp_data(7'h0B, 8'hA0, 1'b1, 1'b0);
        send(8'h50); exp_data(7'h0B, 8'h50, 1'b0, 1'b1);
        send(8'hCC); exp_end(2, 1, stamp);
        idle(3);

        // Truncated packet: a byte on the last idle cycle survives, then a real timeout.
        send(8'hEE); send(8'h0F); send(8'h03);
        send(8'h01); exp_data(7'h0F, 8'h01, 1'b1, 1'b0);
        idle(TO - 1);
        send(8'h02); exp_data(7'h0F, 8'h02, 1'b0, 1'b0);
        exp_end(2, 2, stamp + TO);
        idle(TO + 4);
        chk("busy_after_timeout", {30'd0, if_c.busy, if_n.busy}, 32'd0);
        send(8'hEE); send(8'h00); send(8'h01);
        send(8'hAE); exp_data(7'h00, 8'hAE, 1'b1, 1'b1);
        send(8'hCC); exp_end(2, 1, stamp);
        idle(3);

        // Back-to-back packet (CRC 21), next prefix immediately after, reset mid-payload.
        send(8'hEE); send(8'h05); send(8'h02);
        send(8'h12); exp_data(7'h05, 8'h12, 1'b1, 1'b0);
        send(8'h34); exp_data(7'h05, 8'h34, 1'b0, 1'b1);
        send(8'h21); exp_end(1, 1, stamp);
        send(8'hEE); send(8'h06); send(8'h03);
        send(8'hAA); exp_data(7'h06, 8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("after_reset");
        idle(TO + 4);
        chk("busy_idle_after_reset", {30'd0, if_c.busy, if_n.busy}, 32'd0);

        // Maximum length 255: payload 00..FE, CRC 01^FF^FF = 01.
        send(8'hEE); send(8'h01); send(8'hFF);
        for (int i = 0; i < 255; i++) begin
            send(8'(i));
            exp_data(7'h01, 8'(i), i == 0, i == 254);
        end
        send(8'h01); exp_end(1, 1, stamp);
        idle(4);
        chk("busy_after_len255", {30'd0, if_c.busy, if_n.busy}, 32'd0);

        chk("pending_crc", q_c.size(), 32'd0);
        chk("pending_nocrc", q_n.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
